// File: rtl/fx2_fifo_master.sv
// FPGA-side master for the FX2 slave-FIFO interface: drains EP2 command bytes toward the
// parser, pushes timetag bytes into EP6 and commits short IN packets after an idle timeout.
module fx2_fifo_master #(
  parameter int unsigned PKTEND_TIMEOUT = 1024,
  parameter int unsigned PKT_SIZE       = 512,
  parameter int unsigned FLAG_LAT       = 2
) (
  input  logic       fx2_clk,
  input  logic       reset_n,
  input  logic [3:0] fx2_flags,
  inout  wire  [7:0] fx2_FD,
  output logic [1:0] fx2_FIFOADR,
  output logic       fx2_SLRD,
  output logic       fx2_SLWR,
  output logic       fx2_SLOE,
  output logic       fx2_PKTEND,
  output logic [7:0] cmd_data,
  output logic       cmd_avail,
  input  logic       cmd_ack,
  input  logic [7:0] data,
  input  logic       data_avail,
  output logic       data_accepted
);

  localparam int unsigned IdleW = $clog2(PKTEND_TIMEOUT + 1);
  localparam int unsigned ByteW = (PKT_SIZE > 1) ? $clog2(PKT_SIZE) : 1;
  localparam int unsigned SetW  = (FLAG_LAT > 1) ? $clog2(FLAG_LAT) : 1;

  localparam logic [IdleW-1:0] IdleMax  = IdleW'(PKTEND_TIMEOUT);
  localparam logic [ByteW-1:0] ByteLast = ByteW'(PKT_SIZE - 1);
  localparam logic [SetW-1:0]  SetLast  = SetW'(FLAG_LAT - 1);

  localparam logic [1:0] AddrEp2 = 2'b00;
  localparam logic [1:0] AddrEp6 = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdStrobe,
    StWrAddr,
    StWrStrobe,
    StPktEnd,
    StSettle
  } state_t;

  state_t           state;
  logic [SetW-1:0]  settle_cnt;
  logic [ByteW-1:0] byte_cnt;
  logic [IdleW-1:0] idle_cnt;
  logic             last_wr;
  logic [7:0]       wr_byte;
  logic             fd_oe;

  logic ep2_empty;
  logic ep6_full;
  logic rd_ok;
  logic wr_ok;
  logic pkt_ok;
  logic pick_wr;
  logic unused_flags;

  assign ep2_empty    = fx2_flags[0];
  assign ep6_full     = fx2_flags[1];
  assign unused_flags = ^fx2_flags[3:2];

  assign rd_ok   = !ep2_empty && !cmd_avail;
  assign wr_ok   = !ep6_full && data_avail;
  assign pkt_ok  = (idle_cnt == IdleMax) && !ep6_full;
  // When both directions are ready, serve the one that did not go last.
  assign pick_wr = wr_ok && (!rd_ok || !last_wr);

  assign fx2_FD = fd_oe ? wr_byte : 8'hzz;

  always_ff @(posedge fx2_clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= StIdle;
      settle_cnt    <= '0;
      byte_cnt      <= '0;
      idle_cnt      <= '0;
      last_wr       <= 1'b0;
      wr_byte       <= 8'h00;
      fd_oe         <= 1'b0;
      fx2_FIFOADR   <= AddrEp2;
      fx2_SLRD      <= 1'b0;
      fx2_SLWR      <= 1'b0;
      fx2_SLOE      <= 1'b0;
      fx2_PKTEND    <= 1'b0;
      cmd_data      <= 8'h00;
      cmd_avail     <= 1'b0;
      data_accepted <= 1'b0;
    end else begin
      data_accepted <= 1'b0;
      if (cmd_avail && cmd_ack) begin
        cmd_avail <= 1'b0;
      end
      // Idle timer only runs while a short packet is pending; overridden below on writes.
      if ((byte_cnt != '0) && (idle_cnt != IdleMax)) begin
        idle_cnt <= idle_cnt + 1'b1;
      end

      case (state)
        StIdle: begin
          if (pick_wr) begin
            state         <= StWrAddr;
            fx2_FIFOADR   <= AddrEp6;
            fx2_SLOE      <= 1'b0;
            wr_byte       <= data;
            data_accepted <= 1'b1;
            last_wr       <= 1'b1;
          end else if (pkt_ok && !wr_ok) begin
            state       <= StPktEnd;
            fx2_FIFOADR <= AddrEp6;
            fx2_PKTEND  <= 1'b1;
            byte_cnt    <= '0;
            idle_cnt    <= '0;
          end else if (rd_ok) begin
            state       <= StRdAddr;
            fx2_FIFOADR <= AddrEp2;
            fx2_SLOE    <= 1'b1;
            last_wr     <= 1'b0;
          end
        end

        StRdAddr: begin
          state    <= StRdStrobe;
          fx2_SLRD <= 1'b1;
        end

        StRdStrobe: begin
          cmd_data   <= fx2_FD;
          cmd_avail  <= 1'b1;
          fx2_SLRD   <= 1'b0;
          fx2_SLOE   <= 1'b0;
          settle_cnt <= '0;
          state      <= StSettle;
        end

        StWrAddr: begin
          // A byte already captured is held here until EP6 has room again.
          if (!ep6_full) begin
            state    <= StWrStrobe;
            fd_oe    <= 1'b1;
            fx2_SLWR <= 1'b1;
          end
        end

        StWrStrobe: begin
          fx2_SLWR   <= 1'b0;
          fd_oe      <= 1'b0;
          byte_cnt   <= (byte_cnt == ByteLast) ? '0 : byte_cnt + 1'b1;
          idle_cnt   <= '0;
          settle_cnt <= '0;
          state      <= StSettle;
        end

        StPktEnd: begin
          fx2_PKTEND <= 1'b0;
          settle_cnt <= '0;
          state      <= StSettle;
        end

        StSettle: begin
          if (settle_cnt == SetLast) begin
            state <= StIdle;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fx2_fifo_master.sv
// Directed bench for fx2_fifo_master: behavioural FX2 FIFOs, data source and parser
// around the DUT, with protocol monitors feeding scenario tasks.
module tb_fx2_fifo_master;

  localparam int unsigned TO = 1024;
  localparam int unsigned PS = 512;
  localparam int unsigned FL = 2;

  logic       fx2_clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] fx2_flags;
  wire  [7:0] fx2_FD;
  logic [1:0] fx2_FIFOADR;
  logic       fx2_SLRD, fx2_SLWR, fx2_SLOE, fx2_PKTEND;
  logic [7:0] cmd_data;
  logic       cmd_avail;
  logic       cmd_ack;
  logic [7:0] data;
  logic       data_avail;
  logic       data_accepted;

  int tests = 0;
  int fails = 0;

  fx2_fifo_master #(
    .PKTEND_TIMEOUT(TO),
    .PKT_SIZE      (PS),
    .FLAG_LAT      (FL)
  ) dut (
    .fx2_clk      (fx2_clk),
    .reset_n      (reset_n),
    .fx2_flags    (fx2_flags),
    .fx2_FD       (fx2_FD),
    .fx2_FIFOADR  (fx2_FIFOADR),
    .fx2_SLRD     (fx2_SLRD),
    .fx2_SLWR     (fx2_SLWR),
    .fx2_SLOE     (fx2_SLOE),
    .fx2_PKTEND   (fx2_PKTEND),
    .cmd_data     (cmd_data),
    .cmd_avail    (cmd_avail),
    .cmd_ack      (cmd_ack),
    .data         (data),
    .data_avail   (data_avail),
    .data_accepted(data_accepted)
  );

  always #5 fx2_clk = ~fx2_clk;

  // A released bus reads as all ones; bench data never uses 8'hff.
  pullup (fx2_FD);

  // FX2 model: EP2 OUT FIFO and EP6 IN FIFO.
  logic [7:0] ep2_mem [0:63];
  int         ep2_wr = 0;
  int         ep2_rd = 0;
  logic [7:0] ep6_mem [0:1023];
  int         ep6_cnt = 0;
  logic       force_full = 1'b0;
  logic       ep2_empty;

  assign ep2_empty = (ep2_rd == ep2_wr);
  assign fx2_flags = {2'b00, force_full, ep2_empty};
  assign fx2_FD    = fx2_SLOE ? ep2_mem[ep2_rd[5:0]] : 8'hzz;

  // Data source.
  logic [7:0] src_mem [0:1023];
  int         src_len = 0;
  int         src_idx = 0;
  assign data_avail = (src_idx < src_len);
  assign data       = src_mem[src_idx[9:0]];

  // Parser: manual ack from tasks, or automatic ack one cycle after cmd_avail.
  logic ack_man  = 1'b0;
  logic auto_ack = 1'b0;
  logic ack_auto = 1'b0;
  assign cmd_ack = ack_man | ack_auto;

  // Monitors.
  int   cyc = 0;
  int   rd_cnt = 0;
  int   acc_cnt = 0;
  int   pkt_cnt = 0;
  int   pkt_time = 0;
  int   last_wr_time = 0;
  int   proto_viol = 0;
  int   fd_viol = 0;
  int   cmd_viol = 0;
  int   op_n = 0;
  logic op_log [0:255];
  logic prev_sloe = 1'b0;
  logic prev_slrd = 1'b0;
  logic held_v = 1'b0;
  logic [7:0] held_d = 8'h00;

  always @(posedge fx2_clk) begin
    cyc       <= cyc + 1;
    prev_sloe <= fx2_SLOE;
    prev_slrd <= fx2_SLRD;
    held_v    <= cmd_avail && !cmd_ack;
    held_d    <= cmd_data;
    ack_auto  <= auto_ack && cmd_avail && !ack_auto;
    if (fx2_SLRD) begin
      rd_cnt <= rd_cnt + 1;
      if (!ep2_empty) ep2_rd <= ep2_rd + 1;
      if (op_n < 256) op_log[op_n] <= 1'b0;
      op_n <= op_n + 1;
    end else if (fx2_SLWR) begin
      ep6_mem[ep6_cnt[9:0]] <= fx2_FD;
      ep6_cnt      <= ep6_cnt + 1;
      last_wr_time <= cyc;
      if (op_n < 256) op_log[op_n] <= 1'b1;
      op_n <= op_n + 1;
    end
    if (fx2_PKTEND) begin
      pkt_cnt  <= pkt_cnt + 1;
      pkt_time <= cyc;
    end
    if (data_accepted) begin
      acc_cnt <= acc_cnt + 1;
      src_idx <= src_idx + 1;
    end
  end

  always @(negedge fx2_clk) begin
    if (fx2_SLRD && (fx2_FIFOADR != 2'b00 || !fx2_SLOE || prev_slrd)) proto_viol <= proto_viol + 1;
    if ((fx2_SLWR || fx2_PKTEND) && fx2_FIFOADR != 2'b10) proto_viol <= proto_viol + 1;
    if (!fx2_SLOE && !fx2_SLWR && fx2_FD !== 8'hff) fd_viol <= fd_viol + 1;
    if (fx2_SLWR && (fx2_SLOE || prev_sloe)) fd_viol <= fd_viol + 1;
    if (held_v && (!cmd_avail || cmd_data !== held_d)) cmd_viol <= cmd_viol + 1;
  end

  task automatic test_reset;
    logic [7:0] ctl;
    #2 reset_n = 1'b0;
    @(negedge fx2_clk);
    ctl = {fx2_FIFOADR, fx2_SLRD, fx2_SLWR, fx2_SLOE, fx2_PKTEND, cmd_avail, data_accepted};
    tests++;
    if (ctl !== 8'h00) begin
      fails++;
      $display("FAIL reset_ctl: got %b expected 00000000", ctl);
    end
    tests++;
    if (cmd_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_cmd_data: got %h expected 00", cmd_data);
    end
    tests++;
    if (fx2_FD !== 8'hff) begin
      fails++;
      $display("FAIL reset_fd_released: got %h expected ff (released)", fx2_FD);
    end
    reset_n = 1'b1;
    repeat (5) @(negedge fx2_clk);
    tests++;
    if (rd_cnt != 0 || ep6_cnt != 0 || pkt_cnt != 0) begin
      fails++;
      $display("FAIL idle_no_strobes: rd=%0d wr=%0d pkt=%0d expected 0 0 0", rd_cnt, ep6_cnt,
               pkt_cnt);
    end
  endtask

  task automatic test_cmd_stream;
    logic [7:0] exp [0:6];
    int r0;
    int k;
    exp = '{8'h05, 8'h04, 8'h00, 8'h00, 8'h00, 8'h40, 8'h02};
    r0 = rd_cnt;
    for (int i = 0; i < 7; i++) begin
      ep2_mem[ep2_wr[5:0]] = exp[i];
      ep2_wr++;
    end
    for (int i = 0; i < 7; i++) begin
      k = 0;
      while (!cmd_avail && k < 100) begin
        @(negedge fx2_clk);
        k++;
      end
      tests++;
      if (!cmd_avail) begin
        fails++;
        $display("FAIL cmd_stream_timeout[%0d]: cmd_avail 0 expected 1", i);
      end else if (cmd_data !== exp[i]) begin
        fails++;
        $display("FAIL cmd_stream_byte[%0d]: got %h expected %h", i, cmd_data, exp[i]);
      end
      repeat (2) @(negedge fx2_clk);
      ack_man = 1'b1;
      @(negedge fx2_clk);
      ack_man = 1'b0;
    end
    repeat (10) @(negedge fx2_clk);
    tests++;
    if (rd_cnt - r0 != 7 || proto_viol != 0) begin
      fails++;
      $display("FAIL cmd_stream_slrd: pulses=%0d viol=%0d expected 7 0", rd_cnt - r0, proto_viol);
    end
  endtask

  task automatic test_cmd_withhold;
    int k;
    int r0;
    int bad;
    logic [7:0] d0;
    ep2_mem[ep2_wr[5:0]] = 8'h11;
    ep2_wr++;
    ep2_mem[ep2_wr[5:0]] = 8'h22;
    ep2_wr++;
    k = 0;
    while (!cmd_avail && k < 100) begin
      @(negedge fx2_clk);
      k++;
    end
    tests++;
    if (cmd_data !== 8'h11 || !cmd_avail) begin
      fails++;
      $display("FAIL withhold_first: got %h avail %b expected 11 1", cmd_data, cmd_avail);
    end
    d0 = cmd_data;
    r0 = rd_cnt;
    bad = 0;
    repeat (50) begin
      @(negedge fx2_clk);
      if (!cmd_avail || cmd_data !== d0) bad++;
    end
    tests++;
    if (bad != 0 || rd_cnt != r0) begin
      fails++;
      $display("FAIL withhold_hold: unstable=%0d extra_slrd=%0d expected 0 0", bad, rd_cnt - r0);
    end
    ack_man = 1'b1;
    @(negedge fx2_clk);
    ack_man = 1'b0;
    k = 0;
    while (!cmd_avail && k < 100) begin
      @(negedge fx2_clk);
      k++;
    end
    tests++;
    if (cmd_data !== 8'h22 || !cmd_avail || cmd_viol != 0) begin
      fails++;
      $display("FAIL withhold_next: got %h avail %b viol %0d expected 22 1 0", cmd_data,
               cmd_avail, cmd_viol);
    end
    ack_man = 1'b1;
    @(negedge fx2_clk);
    ack_man = 1'b0;
  endtask

  task automatic test_write_pair;
    int base;
    int a0;
    int p0;
    int k;
    int gap;
    base = ep6_cnt;
    a0 = acc_cnt;
    p0 = pkt_cnt;
    src_mem[src_len[9:0]] = 8'hA5;
    src_mem[src_len[9:0] + 10'd1] = 8'h5A;
    src_len += 2;
    k = 0;
    while (ep6_cnt < base + 2 && k < 100) begin
      @(negedge fx2_clk);
      k++;
    end
    tests++;
    if (ep6_cnt != base + 2 || acc_cnt - a0 != 2) begin
      fails++;
      $display("FAIL write_pair_count: slwr=%0d accepted=%0d expected 2 2", ep6_cnt - base,
               acc_cnt - a0);
    end
    tests++;
    if (ep6_mem[base] !== 8'hA5 || ep6_mem[base + 1] !== 8'h5A) begin
      fails++;
      $display("FAIL write_pair_data: got %h %h expected a5 5a", ep6_mem[base], ep6_mem[base + 1]);
    end
    tests++;
    if (fd_viol != 0) begin
      fails++;
      $display("FAIL fd_turnaround: violations=%0d expected 0", fd_viol);
    end
    k = 0;
    while (pkt_cnt == p0 && k < 2 * TO) begin
      @(negedge fx2_clk);
      k++;
    end
    gap = pkt_time - last_wr_time;
    tests++;
    if (pkt_cnt != p0 + 1 || gap < int'(TO) || gap > int'(TO + FL + 4) || proto_viol != 0) begin
      fails++;
      $display("FAIL pktend_timeout: pulses=%0d gap=%0d viol=%0d expected 1 %0d..%0d 0",
               pkt_cnt - p0, gap, proto_viol, TO, TO + FL + 4);
    end
    repeat (TO + 100) @(negedge fx2_clk);
    tests++;
    if (pkt_cnt != p0 + 1) begin
      fails++;
      $display("FAIL pktend_single: pulses=%0d expected 1", pkt_cnt - p0);
    end
  endtask

  task automatic test_full_packet;
    int base;
    int p0;
    int k;
    int bad;
    base = ep6_cnt;
    p0 = pkt_cnt;
    for (int i = 0; i < int'(PS); i++) begin
      src_mem[src_len[9:0]] = {1'b0, i[6:0]};
      src_len++;
    end
    k = 0;
    while (ep6_cnt < base + int'(PS) && k < 4000) begin
      @(negedge fx2_clk);
      k++;
    end
    bad = 0;
    for (int i = 0; i < int'(PS); i++) begin
      if (ep6_mem[base + i] !== {1'b0, i[6:0]}) bad++;
    end
    tests++;
    if (ep6_cnt != base + int'(PS) || bad != 0) begin
      fails++;
      $display("FAIL full_packet_data: written=%0d bad=%0d expected %0d 0", ep6_cnt - base, bad,
               PS);
    end
    repeat (2 * TO) @(negedge fx2_clk);
    tests++;
    if (pkt_cnt != p0) begin
      fails++;
      $display("FAIL full_packet_no_pktend: pulses=%0d expected 0", pkt_cnt - p0);
    end
  endtask

  task automatic test_ep6_full;
    int base;
    int a0;
    int p0;
    int w1;
    int a1;
    int k;
    int bad;
    base = ep6_cnt;
    a0 = acc_cnt;
    p0 = pkt_cnt;
    for (int i = 0; i < 20; i++) begin
      src_mem[src_len[9:0]] = 8'h80 + 8'(i);
      src_len++;
    end
    k = 0;
    while (ep6_cnt < base + 5 && k < 100) begin
      @(negedge fx2_clk);
      k++;
    end
    force_full = 1'b1;
    @(negedge fx2_clk);
    w1 = ep6_cnt;
    a1 = acc_cnt;
    repeat (100) @(negedge fx2_clk);
    tests++;
    if (ep6_cnt != w1 || acc_cnt != a1) begin
      fails++;
      $display("FAIL full_stall: slwr=%0d accepted=%0d expected 0 0", ep6_cnt - w1, acc_cnt - a1);
    end
    force_full = 1'b0;
    k = 0;
    while (ep6_cnt < base + 20 && k < 500) begin
      @(negedge fx2_clk);
      k++;
    end
    repeat (10) @(negedge fx2_clk);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (ep6_mem[base + i] !== 8'h80 + 8'(i)) bad++;
    end
    tests++;
    if (ep6_cnt != base + 20 || acc_cnt - a0 != 20 || bad != 0) begin
      fails++;
      $display("FAIL full_resume: written=%0d accepted=%0d bad=%0d expected 20 20 0",
               ep6_cnt - base, acc_cnt - a0, bad);
    end
    k = 0;
    while (pkt_cnt == p0 && k < 2 * TO) begin
      @(negedge fx2_clk);
      k++;
    end
    tests++;
    if (pkt_cnt != p0 + 1) begin
      fails++;
      $display("FAIL full_short_pktend: pulses=%0d expected 1", pkt_cnt - p0);
    end
  endtask

  task automatic test_back_to_back;
    int o0;
    int base;
    int k;
    int bad;
    o0 = op_n;
    base = ep6_cnt;
    auto_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ep2_mem[ep2_wr[5:0]] = 8'h30 + 8'(i);
      ep2_wr++;
      src_mem[src_len[9:0]] = 8'h60 + 8'(i);
      src_len++;
    end
    k = 0;
    while ((ep6_cnt < base + 6 || !ep2_empty || cmd_avail) && k < 300) begin
      @(negedge fx2_clk);
      k++;
    end
    repeat (5) @(negedge fx2_clk);
    auto_ack = 1'b0;
    bad = 0;
    for (int i = o0 + 1; i < op_n && i < 256; i++) begin
      if (op_log[i] == op_log[i - 1]) bad++;
    end
    tests++;
    if (op_n - o0 != 12 || bad != 0) begin
      fails++;
      $display("FAIL alternate: ops=%0d repeats=%0d expected 12 0", op_n - o0, bad);
    end
  endtask

  task automatic test_reset_mid_write;
    int k;
    int w0;
    logic [7:0] ctl;
    src_mem[src_len[9:0]] = 8'h77;
    src_len++;
    k = 0;
    do begin
      @(posedge fx2_clk);
      #1;
      k++;
    end while (!fx2_SLWR && k < 50);
    w0 = ep6_cnt;
    tests++;
    if (!fx2_SLWR) begin
      fails++;
      $display("FAIL reset_mid_reach: slwr=0 expected 1");
    end
    reset_n = 1'b0;
    #1;
    ctl = {fx2_FIFOADR, fx2_SLRD, fx2_SLWR, fx2_SLOE, fx2_PKTEND, cmd_avail, data_accepted};
    tests++;
    if (ctl !== 8'h00 || cmd_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_mid_outputs: ctl=%b cmd=%h expected 00000000 00", ctl, cmd_data);
    end
    tests++;
    if (fx2_FD !== 8'hff) begin
      fails++;
      $display("FAIL reset_mid_fd: got %h expected ff (released)", fx2_FD);
    end
    @(negedge fx2_clk);
    tests++;
    if (ep6_cnt != w0) begin
      fails++;
      $display("FAIL reset_mid_dropped: writes=%0d expected 0", ep6_cnt - w0);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge fx2_clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ep2_mem[i] = 8'h00;
    for (int i = 0; i < 1024; i++) begin
      src_mem[i] = 8'h00;
      ep6_mem[i] = 8'h00;
    end
    test_reset();
    test_cmd_stream();
    test_cmd_withhold();
    test_write_pair();
    test_full_packet();
    test_ep6_full();
    test_back_to_back();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
